// File: rtl/armleocpu_mul_frontend_pkg.sv
// Shared definitions for the multiply frontend: req_op encodings, FSM states
// and the operand magnitude helper.
package armleocpu_mul_frontend_pkg;

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULH   = 2'b01,
      OP_MULHSU = 2'b10,
      OP_MULHU  = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_POST,
      ST_DRAIN
   } state_t;

   // Two's-complement absolute value; 0x80000000 stays 0x80000000 as an unsigned magnitude.
   function automatic logic [31:0] magnitude(input logic [31:0] value);
      return value[31] ? (~value + 32'd1) : value;
   endfunction

endpackage

// File: rtl/armleocpu_multiplier.sv
// Unsigned 32x32=64 shift-add multiplier; factors latched on valid,
// ready pulses for one cycle with result held until the next valid.
module armleocpu_multiplier (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid,
   input  logic [31:0] factor0,
   input  logic [31:0] factor1,
   output logic        ready,
   output logic [63:0] result
);

   logic        busy;
   logic [4:0]  count;
   logic [63:0] mcand;
   logic [31:0] mplier;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy   <= 1'b0;
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         result <= '0;
         ready  <= 1'b0;
      end else begin
         ready <= 1'b0;
         if (valid) begin
            busy   <= 1'b1;
            count  <= '0;
            mcand  <= {32'd0, factor0};
            mplier <= factor1;
            result <= '0;
         end else if (busy) begin
            if (mplier[0])
               result <= result + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 5'd1;
            if (count == 5'd31) begin
               busy  <= 1'b0;
               ready <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/armleocpu_mul_frontend.sv
// RISC-V M-extension multiply frontend: sign handling, handshake/kill FSM around armleocpu_multiplier.
// Build option: define ARMLEOCPU_MUL_RESULT_CACHE_EN to enable the last-product cache.
module armleocpu_mul_frontend
   import armleocpu_mul_frontend_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic        kill,
   output logic        resp_valid,
   output logic [31:0] resp_result
);

   state_t      state, state_next;
   op_t         op_in, cur_op;
   logic        neg_in, cur_neg;
   logic [31:0] mag_a_in, mag_b_in, mag_a, mag_b;
   logic        accept, hit;
   logic        core_valid, core_ready;
   logic [63:0] core_result, product, cached_product, signed_product;
   logic [31:0] selected;

   always_comb begin
      op_in    = op_t'(req_op);
      neg_in   = 1'b0;
      mag_a_in = rs1;
      mag_b_in = rs2;
      case (op_in)
         OP_MULH: begin
            neg_in   = rs1[31] ^ rs2[31];
            mag_a_in = magnitude(rs1);
            mag_b_in = magnitude(rs2);
         end
         OP_MULHSU: begin
            neg_in   = rs1[31];
            mag_a_in = magnitude(rs1);
         end
         default: ;
      endcase
   end

   assign accept = (state == ST_IDLE) && req_valid && !kill;

`ifdef ARMLEOCPU_MUL_RESULT_CACHE_EN
   logic        cache_valid;
   logic [31:0] cache_a, cache_b;
   logic [63:0] cache_p;

   assign hit            = cache_valid && (cache_a == mag_a_in) && (cache_b == mag_b_in);
   assign cached_product = cache_p;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cache_valid <= 1'b0;
         cache_a     <= '0;
         cache_b     <= '0;
         cache_p     <= '0;
      end else if (kill) begin
         cache_valid <= 1'b0;
      end else if (state == ST_POST) begin
         cache_valid <= 1'b1;
         cache_a     <= mag_a;
         cache_b     <= mag_b;
         cache_p     <= product;
      end
   end
`else
   assign hit            = 1'b0;
   assign cached_product = '0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // A kill landing on the core-ready cycle goes straight to IDLE: the core is already done.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      core_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (accept)
               state_next = hit ? ST_POST : ST_START;
         end
         ST_START: begin
            core_valid = 1'b1;
            state_next = kill ? ST_DRAIN : ST_WAIT;
         end
         ST_WAIT: begin
            if (kill)
               state_next = core_ready ? ST_IDLE : ST_DRAIN;
            else if (core_ready)
               state_next = ST_POST;
         end
         ST_POST:  state_next = ST_IDLE;
         ST_DRAIN: if (core_ready) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   armleocpu_multiplier u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   (core_valid),
      .factor0 (mag_a),
      .factor1 (mag_b),
      .ready   (core_ready),
      .result  (core_result)
   );

   always_comb begin
      signed_product = cur_neg ? (~product + 64'd1) : product;
      selected       = (cur_op == OP_MUL) ? signed_product[31:0] : signed_product[63:32];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resp_valid  <= 1'b0;
         resp_result <= '0;
         cur_op      <= OP_MUL;
         cur_neg     <= 1'b0;
         mag_a       <= '0;
         mag_b       <= '0;
         product     <= '0;
      end else begin
         resp_valid <= 1'b0;
         if (accept) begin
            cur_op  <= op_in;
            cur_neg <= neg_in;
            mag_a   <= mag_a_in;
            mag_b   <= mag_b_in;
         end
         if (accept && hit)
            product <= cached_product;
         else if (state == ST_WAIT && core_ready)
            product <= core_result;
         if (state == ST_POST && !kill) begin
            resp_valid  <= 1'b1;
            resp_result <= selected;
         end
      end
   end

endmodule

// File: doc/armleocpu_mul_frontend.md
ARMLEOCPU_MUL_FRONTEND -- requirements
Module: armleocpu_mul_frontend

Interface
REQ-001 SHALL have no parameters.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  frontend can accept a request this cycle.
REQ-006 req_op  input  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-007 rs1  input  32  first operand; signed for MULH and MULHSU.
REQ-008 rs2  input  32  second operand; signed for MULH only.
REQ-009 kill  input  1  pipeline flush; abandons the in-flight request.
REQ-010 resp_valid  output  1  one-cycle pulse; resp_result is valid.
REQ-011 resp_result  output  32  rd value; held until the next resp_valid.

Function
REQ-012 A request SHALL be accepted on a cycle with req_valid=1 and req_ready=1; rs1, rs2 and req_op SHALL be registered on acceptance.
REQ-013 req_ready SHALL be 1 only in IDLE.
REQ-014 States SHALL be IDLE, START, WAIT, POST and DRAIN.
REQ-015 IDLE->START on acceptance; START->WAIT unconditionally; WAIT->POST when core ready=1; POST->IDLE unconditionally.
REQ-016 Operand prep (IDLE, on acceptance): each signed operand SHALL be replaced by its absolute value as an unsigned 32-bit magnitude; 0x80000000 SHALL map to magnitude 0x80000000.
REQ-017 neg flag SHALL be the XOR of the sign bits of the operands treated as signed; MUL and MULHU SHALL have neg=0.
REQ-018 core valid SHALL be 1 for exactly one cycle, in START; the magnitudes SHALL be stable on the core inputs from START until core ready.
REQ-019 POST SHALL take the 64-bit core product P, form R = neg ? (~P + 1) mod 2^64 : P, and select R[31:0] for MUL or R[63:32] otherwise.
REQ-020 resp_valid SHALL be 1 in the cycle after POST; with core ready high in cycle N, resp_valid SHALL be 1 in cycle N+2.
REQ-021 req_valid=1 on the resp_valid cycle SHALL be accepted (back-to-back).
REQ-022 kill in START, WAIT or POST SHALL suppress resp_valid for that request; from START/WAIT the state SHALL go to DRAIN.
REQ-023 kill in POST SHALL go to IDLE.
REQ-024 DRAIN SHALL hold req_ready=0 until core ready=1, then go to IDLE; the core result SHALL be discarded.
REQ-025 kill in IDLE SHALL have no effect; kill and acceptance in the same cycle SHALL drop the request.

Reset
REQ-026 Reset SHALL set state=IDLE, resp_valid=0, resp_result=0, core valid=0, cache valid=0 and the core's own reset.
REQ-027 Reset mid-operation SHALL abandon the request without a response; req_ready SHALL be 1 in the first cycle after rst_n=1.

Configuration
REQ-028 Macro ARMLEOCPU_MUL_RESULT_CACHE_EN: when defined, the block SHALL store the last completed magnitude pair and its raw product P, with a cache-valid bit.
REQ-029 With the macro defined, an accepted request whose magnitudes match a valid entry SHALL go IDLE->POST using the stored P; resp_valid SHALL then be 1 two cycles after acceptance.
REQ-030 With the macro defined, kill and reset SHALL clear cache-valid; a killed request SHALL NOT update the cache.
REQ-031 When the macro is undefined, no cache storage SHALL exist and every request SHALL use the core.

Structure
REQ-032 A shared package/header SHALL hold the req_op encodings (MUL, MULH, MULHSU, MULHU) and the state encodings.
REQ-033 A single sub-module, armleocpu_multiplier (unsigned 32x32=64), SHALL be instantiated with ports clk, rst_n, valid, factor0, factor1, ready and result[63:0].
REQ-034 Sign handling, the FSM and the cache SHALL be local to this block.

Verification
REQ-035 MUL rs1=7, rs2=6 -> resp_result=0x0000002A; resp_valid two cycles after core ready.
REQ-036 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000.
REQ-037 MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU with the same operands -> 0xFFFFFFFE.
REQ-038 MULHU 0x12345678 x 0x9ABCDEF0, kill asserted in WAIT -> no resp_valid, req_ready=0 until core ready, then a new MUL 3 x 5 -> 0x0000000F.
REQ-039 With ARMLEOCPU_MUL_RESULT_CACHE_EN, MULHU 0xFFFFFFFF x 0xFFFFFFFF then MUL with the same operands -> 0x00000001 with resp_valid exactly two cycles after acceptance.
REQ-040 rst_n=0 for one cycle during WAIT -> resp_valid stays 0 and req_ready=1 in the next cycle.
